// File: rtl/rpn_stack_engine.sv
// rtl/rpn_stack_engine.sv - RPN command engine driving an external 32-bit LIFO
// Pops operands, computes, pushes results; tracks occupancy to flag under/overflow.
module rpn_stack_engine #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_data,
  output logic        stk_push,
  output logic        stk_pop,
  output logic [31:0] stk_data,
  input  logic [31:0] stk_out,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        err,
  output logic        err_code,
  output logic [5:0]  depth
);

  localparam logic [2:0] OP_PUSH   = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_AND    = 3'd3;
  localparam logic [2:0] OP_OR     = 3'd4;
  localparam logic [2:0] OP_XOR    = 3'd5;
  localparam logic [2:0] OP_DUP    = 3'd6;
  localparam logic [2:0] OP_POPOUT = 3'd7;

  localparam logic [5:0] FULL = 6'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP1  = 3'd1,
    POP2  = 3'd2,
    CAP   = 3'd3,
    PUSH1 = 3'd4,
    PUSH2 = 3'd5,
    OUT   = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] b_q, b_d;
  logic [31:0] r_q, r_d;
  logic [31:0] res_q, res_d;
  logic        err_code_q, err_code_d;
  logic [5:0]  depth_q, depth_d;

  function automatic logic [31:0] alu(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] y;
    y = 32'd0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = 32'd0;
    endcase
    return y;
  endfunction

  function automatic logic is_binary(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    r_d        = r_q;
    res_d      = res_q;
    err_code_d = err_code_q;
    in_ready   = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_data   = 32'd0;
    res_valid  = 1'b0;
    err        = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d = in_op;
          // Legality is judged once, against the occupancy seen at accept.
          case (in_op)
            OP_PUSH: begin
              if (depth_q == FULL) begin
                err_code_d = 1'b1;
                state_d    = ERR;
              end else begin
                r_d     = in_data;
                state_d = PUSH1;
              end
            end
            OP_DUP: begin
              if (depth_q == 6'd0) begin
                err_code_d = 1'b0;
                state_d    = ERR;
              end else if (depth_q == FULL) begin
                err_code_d = 1'b1;
                state_d    = ERR;
              end else begin
                state_d = POP1;
              end
            end
            OP_POPOUT: begin
              if (depth_q == 6'd0) begin
                err_code_d = 1'b0;
                state_d    = ERR;
              end else begin
                state_d = POP1;
              end
            end
            default: begin
              if (depth_q < 6'd2) begin
                err_code_d = 1'b0;
                state_d    = ERR;
              end else begin
                state_d = POP1;
              end
            end
          endcase
        end
      end
      POP1: begin
        stk_pop = 1'b1;
        state_d = is_binary(op_q) ? POP2 : CAP;
      end
      POP2: begin
        stk_pop = 1'b1;
        b_d     = stk_out;
        state_d = CAP;
      end
      CAP: begin
        if (op_q == OP_POPOUT) begin
          res_d   = stk_out;
          state_d = OUT;
        end else if (op_q == OP_DUP) begin
          r_d     = stk_out;
          state_d = PUSH1;
        end else begin
          // stk_out holds the deeper operand a; b was captured a cycle earlier.
          r_d     = alu(op_q, stk_out, b_q);
          state_d = PUSH1;
        end
      end
      PUSH1: begin
        stk_push = 1'b1;
        stk_data = r_q;
        state_d  = (op_q == OP_DUP) ? PUSH2 : IDLE;
      end
      PUSH2: begin
        stk_push = 1'b1;
        stk_data = r_q;
        state_d  = IDLE;
      end
      OUT: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    depth_d = depth_q;
    if (stk_push) begin
      depth_d = depth_q + 6'd1;
    end else if (stk_pop) begin
      depth_d = depth_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_PUSH;
      b_q        <= 32'd0;
      r_q        <= 32'd0;
      res_q      <= 32'd0;
      err_code_q <= 1'b0;
      depth_q    <= 6'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_q        <= b_d;
      r_q        <= r_d;
      res_q      <= res_d;
      err_code_q <= err_code_d;
      depth_q    <= depth_d;
    end
  end

  assign res_data = res_q;
  assign err_code = err_code_q;
  assign depth    = depth_q;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// tb/tb_rpn_stack_engine.sv - directed bench for rpn_stack_engine with a behavioural LIFO
module tb_rpn_stack_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_data;
  logic [31:0] stk_out;
  logic        res_valid;
  logic [31:0] res_data;
  logic        err;
  logic        err_code;
  logic [5:0]  depth;

  int checks = 0;
  int failures = 0;

  rpn_stack_engine #(.DEPTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_data(stk_data), .stk_out(stk_out), .res_valid(res_valid),
    .res_data(res_data), .err(err), .err_code(err_code), .depth(depth)
  );

  always #5 clk = ~clk;

  // Behavioural 32x32 LIFO: pop data appears the cycle after stk_pop.
  logic [31:0] mem [0:31];
  int sp = 0;
  always @(posedge clk) begin
    if (rst) begin
      sp      <= 0;
      stk_out <= 32'd0;
    end else begin
      if (stk_pop && sp > 0) begin
        stk_out <= mem[sp-1];
        sp      <= sp - 1;
      end
      if (stk_push && sp < 32) begin
        mem[sp] <= stk_data;
        sp      <= sp + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int push_cnt = 0, pop_cnt = 0, res_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_push_cyc = 0;
  always @(negedge clk) begin
    if (stk_push) begin push_cnt++; last_push_cyc = cyc; end
    if (stk_pop) pop_cnt++;
    if (stk_push && stk_pop) both_cnt++;
    if (res_valid) res_cnt++;
    if (err) err_cnt++;
  end

  int acc_cyc = 0;
  int ready_delay = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("idle_timeout", 32'(n), 32'd0);
    in_valid = 1'b1; in_op = op; in_data = d; acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 32'd0;
    n = 1;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("done_timeout", 32'(n), 32'd0);
    ready_delay = n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int p0, e0, r0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_strobes", {29'd0, stk_push, stk_pop, err}, 32'd0);
    chk("rst_stk_data", stk_data, 32'd0);
    chk("rst_res", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    rst = 1'b0;

    // 5 - 3
    do_cmd(3'd0, 32'd5);
    do_cmd(3'd0, 32'd3);
    chk("push_depth", 32'(depth), 32'd2);
    do_cmd(3'd2, 32'd0);
    chk("sub_push_lat", 32'(last_push_cyc - acc_cyc), 32'd4);
    chk("sub_ready_lat", 32'(ready_delay), 32'd5);
    chk("sub_depth", 32'(depth), 32'd1);
    r0 = res_cnt;
    do_cmd(3'd7, 32'd0);
    chk("sub_res_pulses", 32'(res_cnt - r0), 32'd1);
    chk("sub_res_data", res_data, 32'd2);
    chk("sub_final_depth", 32'(depth), 32'd0);

    // wraparound add
    do_cmd(3'd0, 32'hFFFF_FFFF);
    do_cmd(3'd0, 32'd2);
    do_cmd(3'd1, 32'd0);
    do_cmd(3'd7, 32'd0);
    chk("add_wrap", res_data, 32'h0000_0001);
    chk("add_wrap_depth", 32'(depth), 32'd0);

    // underflow
    do_reset();
    p0 = pop_cnt; e0 = err_cnt;
    do_cmd(3'd1, 32'd0);
    chk("uf_err", 32'(err_cnt - e0), 32'd1);
    chk("uf_code", 32'(err_code), 32'd0);
    chk("uf_no_pop", 32'(pop_cnt - p0), 32'd0);
    chk("uf_depth", 32'(depth), 32'd0);
    do_cmd(3'd0, 32'd1);
    e0 = err_cnt;
    do_cmd(3'd1, 32'd0);
    chk("uf2_err", 32'(err_cnt - e0), 32'd1);
    chk("uf2_depth", 32'(depth), 32'd1);
    chk("uf2_no_pop", 32'(pop_cnt - p0), 32'd0);

    // overflow at full
    do_reset();
    for (int i = 1; i <= 32; i++) do_cmd(3'd0, 32'(i));
    chk("full_depth", 32'(depth), 32'd32);
    p0 = push_cnt; e0 = err_cnt;
    do_cmd(3'd0, 32'hDEAD);
    chk("of_err", 32'(err_cnt - e0), 32'd1);
    chk("of_code", 32'(err_code), 32'd1);
    chk("of_depth", 32'(depth), 32'd32);
    chk("of_no_push", 32'(push_cnt - p0), 32'd0);
    do_cmd(3'd6, 32'd0);
    chk("dup_of_err", 32'(err_cnt - e0), 32'd2);
    chk("dup_of_code", 32'(err_code), 32'd1);
    chk("dup_of_no_push", 32'(push_cnt - p0), 32'd0);
    do_cmd(3'd5, 32'd0);
    chk("xor_full_depth", 32'(depth), 32'd31);
    chk("xor_full_noerr", 32'(err_cnt - e0), 32'd2);
    chk("err_code_held", 32'(err_code), 32'd1);
    do_cmd(3'd7, 32'd0);
    chk("xor_full_res", res_data, 32'd63);
    chk("xor_after_depth", 32'(depth), 32'd30);

    // DUP then ADD
    do_reset();
    do_cmd(3'd0, 32'd7);
    do_cmd(3'd6, 32'd0);
    chk("dup_depth", 32'(depth), 32'd2);
    do_cmd(3'd1, 32'd0);
    do_cmd(3'd7, 32'd0);
    chk("dup_add_res", res_data, 32'd14);
    chk("dup_add_depth", 32'(depth), 32'd0);

    // reset during POP2 of an ADD
    do_reset();
    do_cmd(3'd0, 32'd1);
    do_cmd(3'd0, 32'd2);
    p0 = push_cnt;
    in_valid = 1'b1; in_op = 3'd1;
    @(posedge clk); #1;              // accepted, now POP1
    in_valid = 1'b0;
    @(posedge clk); #1;              // now POP2
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;              // first cycle after release
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_depth", 32'(depth), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_push", 32'(push_cnt - p0), 32'd0);
    chk("never_both", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpn_stack_engine.md
RPN_STACK_ENGINE -- requirements
Module: rpn_stack_engine

Interface
REQ-001 Parameter: DEPTH, 32, capacity of the attached 32x32 LIFO; the engine never exceeds it.
REQ-002 Port: clk  input  1  sole clock, all state updates on posedge.
REQ-003 Port: rst  input  1  synchronous, active-high reset; the same signal also resets the attached LIFO.
REQ-004 Port: in_valid  input  1  command present.
REQ-005 Port: in_ready  output  1  engine can accept a command (state IDLE).
REQ-006 Port: in_op  input  3  opcode: 0 PUSH, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 DUP, 7 POPOUT.
REQ-007 Port: in_data  input  32  operand for PUSH; ignored for other opcodes.
REQ-008 Port: stk_push  output  1  push strobe to the LIFO.
REQ-009 Port: stk_pop  output  1  pop strobe to the LIFO.
REQ-010 Port: stk_data  output  32  push data to the LIFO.
REQ-011 Port: stk_out  input  32  LIFO pop data, valid the cycle after stk_pop.
REQ-012 Port: res_valid  output  1  one-cycle strobe, POPOUT result.
REQ-013 Port: res_data  output  32  POPOUT result, held until next POPOUT.
REQ-014 Port: err  output  1  one-cycle error strobe.
REQ-015 Port: err_code  output  1  0 underflow, 1 overflow; held until next error.
REQ-016 Port: depth  output  6  current LIFO occupancy, 0..32.

Function
REQ-017 Handshake: command accepted on a cycle with in_valid=1 and in_ready=1; in_ready=1 only in IDLE.
REQ-018 FSM states: IDLE, POP1, POP2, CAP, PUSH1, PUSH2, OUT, ERR; stk_push is 1 only in PUSH1/PUSH2, stk_pop is 1 only in POP1/POP2; never both in one cycle.
REQ-019 Binary ops (1-5): IDLE -> POP1 (pop b) -> POP2 (b <= stk_out, pop a) -> CAP (r <= stk_out op b) -> PUSH1 (push r) -> IDLE; stk_push occurs 4 cycles after accept, in_ready returns 5 cycles after accept.
REQ-020 SUB computes a - b, where a is the deeper operand; ADD/SUB are modulo 2^32, with no carry or borrow flag.
REQ-021 PUSH: r <= in_data at accept, then IDLE -> PUSH1 -> IDLE.
REQ-022 DUP: IDLE -> POP1 -> CAP (r <= stk_out) -> PUSH1 -> PUSH2 -> IDLE; net depth +1.
REQ-023 POPOUT: IDLE -> POP1 -> CAP (res_data <= stk_out) -> OUT (res_valid=1) -> IDLE; net depth -1.
REQ-024 stk_data equals r in PUSH1/PUSH2, else 0.
REQ-025 depth is incremented on each stk_push and decremented on each stk_pop, registered.
REQ-026 Underflow, checked at accept: binary op with depth<2, or DUP/POPOUT with depth=0 -> ERR, err_code=0.
REQ-027 Overflow, checked at accept: PUSH or DUP with depth=DEPTH -> ERR, err_code=1.
REQ-028 ERR lasts one cycle with err=1, then IDLE; the command is consumed, and no stack strobes are issued for it.
REQ-029 A binary op never overflows, because it is net -1.
REQ-030 in_valid while not in IDLE is ignored; no command is queued.

Reset
REQ-031 On rst=1 at posedge: state IDLE, depth=0, r=0, stk_push=0, stk_pop=0, stk_data=0, res_valid=0, res_data=0, err=0, err_code=0.
REQ-032 Reset mid-operation aborts the command with no further strobes; in_ready=1 in the cycle after reset is released.
REQ-033 rst has priority over any accept in the same cycle.

Verification
REQ-034 Reset; PUSH 5, PUSH 3, SUB, POPOUT -> res_valid pulse with res_data=2, depth=0, SUB push 4 cycles after accept.
REQ-035 PUSH 0xFFFFFFFF, PUSH 2, ADD, POPOUT -> res_data=0x00000001.
REQ-036 From reset, ADD -> err=1, err_code=0, no stk_pop, depth=0; then PUSH 1, ADD -> underflow again, depth=1.
REQ-037 32 PUSHes -> depth=32; then PUSH -> err_code=1, depth=32, no stk_push; DUP -> overflow; XOR -> succeeds, depth=31.
REQ-038 PUSH 7, DUP, ADD, POPOUT -> res_data=14, depth=0.
REQ-039 PUSH 1, PUSH 2, ADD, with rst asserted in POP2 -> no stk_push, depth=0, in_ready=1 in the cycle after release.
